instr_fetch_queue: RTL and testbench

//  Decoupling FIFO between the Fetch stage and Decode. Buffers fetched
//  {pc, instruction} pairs so that backpressure from Decode/Rename (RS, ROB,
//  LSQ or free list full) stalls fetch without losing instructions.
//  It also tracks end-of-program and raises drained once the last

---
 rtl/instr_fetch_queue.sv | 137 +++++++++++++
 tb/tb_instr_fetch_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Decoupling FIFO between Fetch and Decode. Buffers {pc, instruction} pairs
//   so that backpressure from Decode stalls Fetch without losing instructions.
//   Tracks end-of-program and raises drained once the last buffered
//   instruction has been handed to Decode.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   flush                 synchronous clear of all entries, returns to RUN
//   enq_valid/enq_ready   write handshake from Fetch (enq_instr, enq_pc)
//   fetch_done            Fetch has no more instructions (level)
//   deq_valid/deq_ready   read handshake to Decode (deq_instr, deq_pc)
//   count, full, empty    occupancy status
//   drained               fetch_done seen and every entry dequeued
module instr_fetch_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               enq_valid,
  input  logic [INSTR_W-1:0] enq_instr,
  input  logic [PC_W-1:0]    enq_pc,
  output logic               enq_ready,
  input  logic               fetch_done,
  output logic               deq_valid,
  output logic [INSTR_W-1:0] deq_instr,
  output logic [PC_W-1:0]    deq_pc,
  input  logic               deq_ready,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               drained
);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PC_W+INSTR_W-1:0] mem_q [DEPTH];

  logic enq_fire;
  logic deq_fire;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign deq_valid = !empty;

  // flush suppresses both handshakes in its cycle
  assign enq_fire = enq_valid && enq_ready && !flush;
  assign deq_fire = deq_valid && deq_ready && !flush;

  // Pointer and occupancy next-state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PTR_W'(1);
      if (deq_fire) head_d = head_q + PTR_W'(1);
      if (enq_fire && !deq_fire) count_d = count_q + CNT_W'(1);
      if (deq_fire && !enq_fire) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage survives flush and reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[tail_q] <= {enq_pc, enq_instr};
  end

  always_comb begin
    deq_pc    = '0;
    deq_instr = '0;
    if (!empty) {deq_pc, deq_instr} = mem_q[head_q];
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StRun;
    else       state_q <= state_d;
  end

  // FSM: next state. Decisions use the post-edge occupancy.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (fetch_done) state_d = (count_d == '0) ? StDone : StDrain;
        end
        StDrain: begin
          if (count_d == '0) state_d = StDone;
        end
        StDone:  state_d = StDone;
        default: state_d = StRun;
      endcase
    end
  end

  // FSM: outputs, from registered state only
  always_comb begin
    enq_ready = 1'b0;
    drained   = 1'b0;
    unique case (state_q)
      StRun:   enq_ready = !full;
      StDrain: enq_ready = 1'b0;
      StDone:  drained   = 1'b1;
      default: enq_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        enq_valid;
  logic [31:0] enq_instr;
  logic [31:0] enq_pc;
  logic        enq_ready;
  logic        fetch_done;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic        deq_ready;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        drained;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_queue #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .enq_valid  (enq_valid),
    .enq_instr  (enq_instr),
    .enq_pc     (enq_pc),
    .enq_ready  (enq_ready),
    .fetch_done (fetch_done),
    .deq_valid  (deq_valid),
    .deq_instr  (deq_instr),
    .deq_pc     (deq_pc),
    .deq_ready  (deq_ready),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .drained    (drained)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, instr} plus a phase number
  // (0 = accepting, 1 = draining after fetch_done, 2 = done).
  logic [63:0] m_q[$];
  int          m_phase = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_phase = 0;
    end else if (flush) begin
      m_q.delete();
      m_phase = 0;
    end else begin
      bit take_in, take_out;
      take_in  = enq_valid && (m_phase == 0) && (m_q.size() < DEPTH);
      take_out = deq_ready && (m_q.size() > 0);
      if (take_out) void'(m_q.pop_front());
      if (take_in) m_q.push_back({enq_pc, enq_instr});
      if (m_phase == 0 && fetch_done) m_phase = (m_q.size() == 0) ? 2 : 1;
      else if (m_phase == 1 && m_q.size() == 0) m_phase = 2;
    end
  end

  // Compare process: every negedge outside reset
  always @(negedge clk) begin
    if (!reset) begin
      int unsigned sz;
      sz = m_q.size();
      check("count", 64'(count), 64'(sz));
      check("full", 64'(full), 64'(sz == DEPTH));
      check("empty", 64'(empty), 64'(sz == 0));
      check("deq_valid", 64'(deq_valid), 64'(sz != 0));
      check("enq_ready", 64'(enq_ready), 64'(m_phase == 0 && sz < DEPTH));
      check("drained", 64'(drained), 64'(m_phase == 2));
      check("deq_data", {deq_pc, deq_instr}, (sz != 0) ? m_q[0] : 64'd0);
    end
  end

  task automatic drive(input bit ev, input logic [31:0] pc, input bit dr, input bit fl,
                       input bit fd);
    enq_valid  = ev;
    enq_pc     = pc;
    enq_instr  = $urandom;
    deq_ready  = dr;
    flush      = fl;
    fetch_done = fd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_empty"}, 64'(empty), 64'd1);
    check({tag, "_full"}, 64'(full), 64'd0);
    check({tag, "_enq_ready"}, 64'(enq_ready), 64'd1);
    check({tag, "_deq_valid"}, 64'(deq_valid), 64'd0);
    check({tag, "_deq_data"}, {deq_pc, deq_instr}, 64'd0);
    check({tag, "_drained"}, 64'(drained), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    enq_valid  = 1'b0;
    enq_instr  = '0;
    enq_pc     = '0;
    deq_ready  = 1'b0;
    fetch_done = 1'b0;
    #3;
    check_reset_state("reset");
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: three entries then stream them out in order
    drive(1, 32'd0, 0, 0, 0);
    drive(1, 32'd4, 0, 0, 0);
    drive(1, 32'd8, 0, 0, 0);
    enq_valid = 1'b0;
    check("t1_count", 64'(count), 64'd3);
    check("t1_head_pc", 64'(deq_pc), 64'd0);
    drive(0, 0, 1, 0, 0);
    check("t1_pc4", 64'(deq_pc), 64'd4);
    drive(0, 0, 1, 0, 0);
    check("t1_pc8", 64'(deq_pc), 64'd8);
    drive(0, 0, 1, 0, 0);
    check("t1_empty", 64'(empty), 64'd1);

    // 2: fill, full blocks a write even with a simultaneous dequeue
    for (int i = 0; i < 8; i++) drive(1, 32'h100 + 32'(4 * i), 0, 0, 0);
    check("t2_full", 64'(full), 64'd1);
    check("t2_enq_ready", 64'(enq_ready), 64'd0);
    drive(1, 32'h200, 1, 0, 0);
    check("t2_count7", 64'(count), 64'd7);
    drive(1, 32'h200, 0, 0, 0);
    check("t2_count8", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0, 0);
    check("t2_empty", 64'(empty), 64'd1);

    // 3: wrap with occupancy between 1 and 2, order pc 0..76
    drive(1, 32'd0, 0, 0, 0);
    for (int i = 1; i < 20; i++) begin
      drive(1, 32'(4 * i), 0, 0, 0);
      enq_valid = 1'b0;
      check("t3_order", 64'(deq_pc), 64'(4 * (i - 1)));
      drive(0, 0, 1, 0, 0);
    end
    check("t3_last", 64'(deq_pc), 64'd76);
    drive(0, 0, 1, 0, 0);
    check("t3_empty", 64'(empty), 64'd1);

    // 4: flush beats simultaneous enqueue and dequeue
    for (int i = 0; i < 4; i++) drive(1, 32'h400 + 32'(4 * i), 0, 0, 0);
    check("t4_count4", 64'(count), 64'd4);
    drive(1, 32'h500, 1, 1, 0);
    check("t4_count", 64'(count), 64'd0);
    check("t4_empty", 64'(empty), 64'd1);
    check("t4_deq_valid", 64'(deq_valid), 64'd0);

    // 5: drain after fetch_done
    drive(1, 32'h600, 0, 0, 0);
    drive(1, 32'h604, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    check("t5_drained_a", 64'(drained), 64'd0);
    check("t5_enq_ready", 64'(enq_ready), 64'd0);
    drive(0, 0, 1, 0, 1);
    check("t5_drained_b", 64'(drained), 64'd0);
    drive(0, 0, 1, 0, 1);
    check("t5_drained_c", 64'(drained), 64'd1);
    drive(1, 32'h700, 0, 0, 1);
    check("t5_ignored", 64'(count), 64'd0);
    drive(0, 0, 0, 1, 0);
    check("t5_rerun", 64'(drained), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 32'($urandom) & 32'hffff_fffc,
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 39) == 0);
    end
    drive(0, 0, 0, 1, 0);

    // 6: asynchronous reset mid-cycle with five entries held
    for (int i = 0; i < 5; i++) drive(1, 32'h800 + 32'(4 * i), 0, 0, 0);
    enq_valid = 1'b0;
    check("t6_count5", 64'(count), 64'd5);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("t6");
    #3;
    reset = 1'b0;
    drive(0, 0, 1, 0, 0);
    check("t6_after", 64'(count), 64'd0);
    for (int i = 0; i < 50; i++) begin
      drive($urandom_range(0, 1) != 0, 32'($urandom), $urandom_range(0, 1) != 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
